// File: rtl/mem_copy_dma.sv
// Block copy engine for a single-port 16-bit byte-addressed memory: one read
// cycle then one write cycle per word, with a running 16-bit modular checksum.
module mem_copy_dma #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [15:0]           len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           checksum,
    output logic                  mem_enable,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(2);

    state_t                state_r, state_s;
    logic [ADDR_WIDTH-1:0] src_r, src_s;
    logic [ADDR_WIDTH-1:0] dst_r, dst_s;
    logic [15:0]           cnt_r, cnt_s;
    logic [15:0]           buf_r, buf_s;
    logic [15:0]           sum_r, sum_s;
    logic                  mis_r, mis_s;

    // Unsigned modular add; the carry out is deliberately dropped.
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
        csum_add = acc + word;
    endfunction

    // Next-state and datapath updates for the copy sequencer.
    always_comb begin
        state_s = state_r;
        src_s   = src_r;
        dst_s   = dst_r;
        cnt_s   = cnt_r;
        buf_s   = buf_r;
        sum_s   = sum_r;
        mis_s   = mis_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    src_s = src_addr;
                    dst_s = dst_addr;
                    cnt_s = len;
                    sum_s = 16'h0000;
                    mis_s = src_addr[0] | dst_addr[0];
                    if (src_addr[0] | dst_addr[0]) begin
                        state_s = ST_DONE;
                    end else if (len == 16'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                buf_s   = mem_rdata;
                sum_s   = csum_add(sum_r, mem_rdata);
                src_s   = src_r + ADDR_STEP;
                state_s = ST_WR;
            end
            ST_WR: begin
                dst_s = dst_r + ADDR_STEP;
                cnt_s = cnt_r - 16'd1;
                if (cnt_r != 16'd1) begin
                    state_s = ST_RD;
                end else begin
                    state_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer, counter and checksum registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            src_r   <= '0;
            dst_r   <= '0;
            cnt_r   <= 16'h0000;
            buf_r   <= 16'h0000;
            sum_r   <= 16'h0000;
            mis_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            src_r   <= src_s;
            dst_r   <= dst_s;
            cnt_r   <= cnt_s;
            buf_r   <= buf_s;
            sum_r   <= sum_s;
            mis_r   <= mis_s;
        end
    end

    // Outputs are registered from the next state so they line up with state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            mem_enable <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 16'h0000;
        end else begin
            busy       <= (state_s == ST_RD) || (state_s == ST_WR);
            done       <= (state_s == ST_DONE);
            err        <= (state_s == ST_DONE) && mis_s;
            mem_enable <= (state_s == ST_RD) || (state_s == ST_WR);
            mem_wr     <= (state_s == ST_WR);
            mem_addr   <= (state_s == ST_RD) ? src_s :
                          (state_s == ST_WR) ? dst_s : '0;
            mem_wdata  <= (state_s == ST_WR) ? buf_s : 16'h0000;
        end
    end

    assign checksum = sum_r;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed, table-driven bench for mem_copy_dma with a behavioural memory
// and hand-written sequences for start-while-busy and mid-copy reset.
module tb_mem_copy_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr, dst_addr, len;
    logic        busy, done, err;
    logic [15:0] checksum;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] mem [0:32767];
    logic        bd_we = 1'b0;
    logic [15:0] bd_addr = 16'h0000;
    logic [15:0] bd_data = 16'h0000;

    int n_chk  = 0;
    int n_pass = 0;

    mem_copy_dma #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .err(err), .checksum(checksum),
        .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[15:1]];

    // Memory: DUT writes take priority; backdoor writes preload while idle.
    always @(posedge clk) begin
        if (mem_enable && mem_wr) begin
            mem[mem_addr[15:1]] <= mem_wdata;
        end else if (bd_we) begin
            mem[bd_addr[15:1]] <= bd_data;
        end
    end

    typedef struct {
        logic [15:0]      src;
        logic [15:0]      dst;
        logic [15:0]      n;
        int               init_n;
        logic [0:3][15:0] init_w;
        int               chk_n;
        logic [0:3][15:0] exp_w;
        int               exp_cyc;
        logic             exp_err;
        logic [15:0]      exp_sum;
        int               exp_mem;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; writes one word through the backdoor port.
    task automatic bd_write(input logic [15:0] a, input logic [15:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    function automatic logic [15:0] rd_word(input logic [15:0] a);
        rd_word = mem[a[15:1]];
    endfunction

    // Issue one request and watch every cycle until done or the budget expires.
    task automatic run_copy(input logic [15:0] s_in, input logic [15:0] d_in, input logic [15:0] l_in,
                            output int dcyc, output logic e, output logic [15:0] s,
                            output int mn, output int bad);
        logic aligned;
        logic exp_rd, exp_wr;
        aligned  = !s_in[0] && !d_in[0];
        src_addr = s_in;
        dst_addr = d_in;
        len      = l_in;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        src_addr = 16'hFFFF;
        dst_addr = 16'hFFFF;
        len      = 16'hFFFF;
        dcyc = -1;
        e    = 1'b0;
        s    = 16'h0000;
        mn   = 0;
        bad  = 0;
        for (int c = 1; c <= 100 && dcyc < 0; c++) begin
            @(negedge clk);
            exp_rd = aligned && (c <= 2 * int'(l_in)) && (c % 2 == 1);
            exp_wr = aligned && (c <= 2 * int'(l_in)) && (c % 2 == 0);
            if (mem_enable) mn++;
            if ((mem_enable !== (exp_rd | exp_wr)) || (mem_wr !== exp_wr) || (busy !== (exp_rd | exp_wr))) bad++;
            if (done) begin
                dcyc = c;
                e    = err;
                s    = checksum;
            end
        end
    endtask

    initial begin
        int   dcyc, mn, bad, dones;
        logic e;
        logic [15:0] s;

        vecs[0] = '{16'h0010, 16'h0100, 16'd4, 4, {16'h1111, 16'h2222, 16'h3333, 16'h4444},
                    4, {16'h1111, 16'h2222, 16'h3333, 16'h4444}, 9, 1'b0, 16'hAAAA, 8};
        vecs[1] = '{16'h0040, 16'h0140, 16'd0, 1, {16'h5555, 16'h0000, 16'h0000, 16'h0000},
                    1, {16'hDEAD, 16'h0000, 16'h0000, 16'h0000}, 1, 1'b0, 16'h0000, 0};
        vecs[2] = '{16'h0011, 16'h0300, 16'd2, 0, {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    2, {16'hDEAD, 16'hDEAD, 16'h0000, 16'h0000}, 1, 1'b1, 16'h0000, 0};
        vecs[3] = '{16'hFFFC, 16'h0200, 16'd3, 3, {16'hFFFF, 16'h0002, 16'h0005, 16'h0000},
                    3, {16'hFFFF, 16'h0002, 16'h0005, 16'h0000}, 7, 1'b0, 16'h0006, 6};
        vecs[4] = '{16'h0020, 16'h001C, 16'd4, 4, {16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0},
                    4, {16'hA0A0, 16'hB0B0, 16'hC0C0, 16'hD0D0}, 9, 1'b0, 16'hE2E0, 8};
        vecs[5] = '{16'h0080, 16'h0082, 16'd3, 4, {16'h0001, 16'h0002, 16'h0003, 16'h0004},
                    3, {16'h0001, 16'h0001, 16'h0001, 16'h0000}, 7, 1'b0, 16'h0003, 6};
        vecs[6] = '{16'h0010, 16'h0101, 16'd1, 0, {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                    1, {16'hDEAD, 16'h0000, 16'h0000, 16'h0000}, 1, 1'b1, 16'h0000, 0};

        rst      = 1'b1;
        start    = 1'b0;
        src_addr = 16'h0000;
        dst_addr = 16'h0000;
        len      = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        chk("rst_mem", 32'({mem_enable, mem_wr, mem_addr, mem_wdata}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 4; i++) bd_write(vecs[v].dst + 16'(2 * i), 16'hDEAD);
            for (int i = 0; i < vecs[v].init_n; i++) bd_write(vecs[v].src + 16'(2 * i), vecs[v].init_w[i]);
            run_copy(vecs[v].src, vecs[v].dst, vecs[v].n, dcyc, e, s, mn, bad);
            chk($sformatf("v%0d_done_cycle", v), 32'(dcyc), 32'(vecs[v].exp_cyc));
            chk($sformatf("v%0d_err", v), 32'(e), 32'(vecs[v].exp_err));
            chk($sformatf("v%0d_checksum", v), 32'(s), 32'(vecs[v].exp_sum));
            chk($sformatf("v%0d_mem_cycles", v), 32'(mn), 32'(vecs[v].exp_mem));
            chk($sformatf("v%0d_phase_errors", v), 32'(bad), 32'd0);
            for (int i = 0; i < vecs[v].chk_n; i++)
                chk($sformatf("v%0d_dst_word%0d", v, i), 32'(rd_word(vecs[v].dst + 16'(2 * i))), 32'(vecs[v].exp_w[i]));
            @(negedge clk);
            chk($sformatf("v%0d_done_one_cycle", v), 32'(done), 32'd0);
            chk($sformatf("v%0d_checksum_hold", v), 32'(checksum), 32'(vecs[v].exp_sum));
        end

        // Second start during a copy and during DONE must be ignored.
        for (int i = 0; i < 4; i++) bd_write(16'h0400 + 16'(2 * i), 16'hDEAD);
        for (int i = 0; i < 4; i++) bd_write(16'h0010 + 16'(2 * i), 16'h1111 * 16'(i + 1));
        bd_write(16'h0600, 16'hDEAD);
        src_addr = 16'h0010;
        dst_addr = 16'h0400;
        len      = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mn    = 0;
        dones = 0;
        dcyc  = -1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (mem_enable) mn++;
            if (done) begin
                dones++;
                if (dcyc < 0) dcyc = c;
            end
            if (c == 3 || c == 9) begin
                start    = 1'b1;
                src_addr = 16'h0500;
                dst_addr = 16'h0600;
                len      = 16'd1;
            end else begin
                start = 1'b0;
            end
        end
        chk("busy_start_mem_cycles", 32'(mn), 32'd8);
        chk("busy_start_done_cycle", 32'(dcyc), 32'd9);
        chk("busy_start_done_count", 32'(dones), 32'd1);
        chk("busy_start_ignored_dst", 32'(rd_word(16'h0600)), 32'hDEAD);
        chk("busy_start_dst_last", 32'(rd_word(16'h0406)), 32'h4444);

        // Reset in the second WR cycle aborts the copy without a done pulse.
        for (int i = 0; i < 4; i++) bd_write(16'h0700 + 16'(2 * i), 16'hDEAD);
        src_addr = 16'h0010;
        dst_addr = 16'h0700;
        len      = 16'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_in_wr", 32'({mem_enable, mem_wr}), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_mem_enable", 32'(mem_enable), 32'd0);
        chk("rst_mid_checksum", 32'(checksum), 32'd0);
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_mid_no_done", 32'(dones), 32'd0);
        chk("rst_mid_dst0", 32'(rd_word(16'h0700)), 32'h1111);
        chk("rst_mid_dst1", 32'(rd_word(16'h0702)), 32'h2222);
        chk("rst_mid_dst2", 32'(rd_word(16'h0704)), 32'hDEAD);
        chk("rst_mid_dst3", 32'(rd_word(16'h0706)), 32'hDEAD);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
